// File: rtl/taxi_meter_gen_pkg.sv
// Shared definitions for the taxi fare meter: trip and converter state encodings,
// the active-low seven-segment code table and the saturation limit helper.
package taxi_meter_gen_pkg;

   // Trip state encoding doubles as the external state output value.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StHold  = 2'd3
   } trip_state_e;

   // Binary-to-BCD converter sequencing.
   typedef enum logic [1:0] {
      CvIdle  = 2'd0,
      CvShift = 2'd1,
      CvLatch = 2'd2
   } conv_state_e;

   // Segment order gfedcba, active low.
   localparam logic [6:0] SegBlank = 7'b1111111;
   localparam logic [6:0] SegZero  = 7'b1000000;

   function automatic logic [6:0] seg_code(input logic [3:0] digit);
      logic [6:0] code;
      case (digit)
         4'd0:    code = 7'b1000000;
         4'd1:    code = 7'b1111001;
         4'd2:    code = 7'b0100100;
         4'd3:    code = 7'b0110000;
         4'd4:    code = 7'b0011001;
         4'd5:    code = 7'b0010010;
         4'd6:    code = 7'b0000010;
         4'd7:    code = 7'b1111000;
         4'd8:    code = 7'b0000000;
         4'd9:    code = 7'b0010000;
         default: code = SegBlank;
      endcase
      return code;
   endfunction

   // Largest fare the display can show: 10^digits - 1.
   function automatic int unsigned fare_max(input int unsigned digits);
      int unsigned v;
      v = 1;
      for (int unsigned i = 0; i < digits; i++) begin
         v = v * 10;
      end
      return v - 1;
   endfunction

endpackage

// File: rtl/taxi_meter_gen_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, FARE_W steps,
// then the result is registered on bcd with a one-cycle done pulse.
module bin2bcd_seq
   import taxi_meter_gen_pkg::*;
#(
   parameter int unsigned FARE_W = 16,
   parameter int unsigned DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [FARE_W-1:0]   bin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd
);

   localparam int unsigned BcdW = 4 * DIGITS;
   localparam int unsigned CntW = $clog2(FARE_W + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(FARE_W - 1);

   conv_state_e       cv_state_q, cv_state_d;
   logic [FARE_W-1:0] sh_q, sh_d;
   logic [BcdW-1:0]   work_q, work_d;
   logic [BcdW-1:0]   bcd_q, bcd_d;
   logic [BcdW-1:0]   adj;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              done_q, done_d;
   // The top nibble never overflows because the input is below 10^DIGITS.
   logic              unused_msb;

   assign unused_msb = adj[BcdW-1];

   // State and datapath registers; reset aborts any conversion in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cv_state_q <= CvIdle;
         sh_q       <= '0;
         work_q     <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         cv_state_q <= cv_state_d;
         sh_q       <= sh_d;
         work_q     <= work_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
      end
   end

   // Sequencing: idle -> FARE_W shift steps -> latch result.
   always_comb begin
      cv_state_d = cv_state_q;
      unique case (cv_state_q)
         CvIdle:  if (start) cv_state_d = CvShift;
         CvShift: if (cnt_q == LastCnt) cv_state_d = CvLatch;
         CvLatch: cv_state_d = CvIdle;
         default: cv_state_d = CvIdle;
      endcase
   end

   // Add-3 correction on every nibble >= 5, then shift in the next binary MSB.
   always_comb begin
      sh_d   = sh_q;
      work_d = work_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      adj    = work_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
         end
      end
      case (cv_state_q)
         CvIdle: begin
            if (start) begin
               sh_d   = bin;
               work_d = '0;
               cnt_d  = '0;
            end
         end
         CvShift: begin
            work_d = {adj[BcdW-2:0], sh_q[FARE_W-1]};
            sh_d   = {sh_q[FARE_W-2:0], 1'b0};
            cnt_d  = cnt_q + CntW'(1);
         end
         CvLatch: begin
            bcd_d  = work_q;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Status outputs.
   always_comb begin
      busy = (cv_state_q != CvIdle);
      done = done_q;
      bcd  = bcd_q;
   end

endmodule

// File: rtl/taxi_meter_gen.sv
// Taxi fare meter: trip FSM, distance and waiting-time charging with saturation,
// and a blanked active-low seven-segment display fed by a sequential BCD converter.
module taxi_meter_gen
   import taxi_meter_gen_pkg::*;
#(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned FARE_W     = 16,
   parameter int unsigned PRICE_W    = 4,
   parameter int unsigned DIST_W     = 16,
   parameter int unsigned WAIT_TICKS = 60
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set,
   input  logic [PRICE_W-1:0]  init_cost,
   input  logic [PRICE_W-1:0]  per_cost,
   input  logic [DIST_W-1:0]   add_mile,
   input  logic                night,
   input  logic                start,
   input  logic                pause,
   input  logic                stop,
   input  logic                dist_pulse,
   input  logic                wait_tick,
   output logic [FARE_W-1:0]   fare,
   output logic [DIST_W-1:0]   distance,
   output logic [1:0]          state,
   output logic [7*DIGITS-1:0] seg
);

   localparam int unsigned FareW1 = FARE_W + 1;
   localparam int unsigned FareMax = fare_max(DIGITS);
   localparam logic [FARE_W:0] FareMaxW = FareW1'(FareMax);
   localparam int unsigned WaitW = $clog2(WAIT_TICKS + 1);
   localparam logic [WaitW-1:0] WaitTop = WaitW'(WAIT_TICKS - 1);

   trip_state_e          state_q, state_d;
   logic [FARE_W-1:0]    fare_q, fare_d;
   logic [DIST_W-1:0]    dist_q, dist_d;
   logic [WaitW-1:0]     wcnt_q, wcnt_d;
   logic [PRICE_W-1:0]   init_q, init_d;
   logic [PRICE_W-1:0]   per_q, per_d;
   logic [DIST_W-1:0]    add_mile_q, add_mile_d;
   logic                 night_q, night_d;
   logic                 pending_q, pending_d;
   logic [7*DIGITS-1:0]  seg_q, seg_d;

   logic                 trip_go;
   logic                 cfg_we;
   logic [DIST_W-1:0]    dist_inc;
   logic [PRICE_W:0]     rate;
   logic                 fare_chg;
   logic                 conv_start;
   logic                 conv_busy;
   logic                 conv_done;
   logic [4*DIGITS-1:0]  conv_bcd;
   logic                 seen;
   logic [3:0]           nib;

   // Widened add that clamps at the largest displayable fare.
   function automatic logic [FARE_W-1:0] fare_add(input logic [FARE_W-1:0] base,
                                                  input logic [FARE_W:0]   incr);
      logic [FARE_W:0] sum;
      sum = {1'b0, base} + incr;
      if (sum > FareMaxW) begin
         sum = FareMaxW;
      end
      return sum[FARE_W-1:0];
   endfunction

   // Trip state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Trip next state; stop wins over a pause-level transition.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StHold: begin
            if (start) state_d = StRun;
         end
         StRun: begin
            if (stop)       state_d = StHold;
            else if (pause) state_d = StPause;
         end
         StPause: begin
            if (stop)        state_d = StHold;
            else if (!pause) state_d = StRun;
         end
         default: state_d = StIdle;
      endcase
   end

   // Trip outputs.
   always_comb begin
      state    = state_q;
      fare     = fare_q;
      distance = dist_q;
      seg      = seg_q;
   end

   // Datapath registers: fare, distance, wait count, config, display control.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fare_q      <= '0;
         dist_q      <= '0;
         wcnt_q      <= '0;
         init_q      <= '0;
         per_q       <= '0;
         add_mile_q  <= '0;
         night_q     <= 1'b0;
         pending_q   <= 1'b0;
         seg_q       <= {DIGITS{SegBlank}};
         seg_q[6:0]  <= SegZero;
      end else begin
         fare_q      <= fare_d;
         dist_q      <= dist_d;
         wcnt_q      <= wcnt_d;
         init_q      <= init_d;
         per_q       <= per_d;
         add_mile_q  <= add_mile_d;
         night_q     <= night_d;
         pending_q   <= pending_d;
         seg_q       <= seg_d;
      end
   end

   // Fare, distance and waiting-time charging.
   always_comb begin
      fare_d     = fare_q;
      dist_d     = dist_q;
      wcnt_d     = wcnt_q;
      night_d    = night_q;
      init_d     = init_q;
      per_d      = per_q;
      add_mile_d = add_mile_q;

      trip_go  = start && (state_q == StIdle || state_q == StHold);
      cfg_we   = set && (state_q == StIdle || state_q == StHold);
      dist_inc = (dist_q == '1) ? dist_q : dist_q + DIST_W'(1);
      rate     = night_q ? {per_q, 1'b0} : {1'b0, per_q};

      if (cfg_we) begin
         init_d     = init_cost;
         per_d      = per_cost;
         add_mile_d = add_mile;
      end

      if (trip_go) begin
         fare_d  = fare_add('0, FareW1'(init_q));
         dist_d  = '0;
         wcnt_d  = '0;
         night_d = night;
      end else if (state_q == StRun || state_q == StPause) begin
         if (dist_pulse) begin
            dist_d = dist_inc;
            if (state_q == StRun && dist_inc > add_mile_q) begin
               fare_d = fare_add(fare_q, FareW1'(rate));
            end
         end
         if (state_q == StPause && wait_tick) begin
            if (wcnt_q == WaitTop) begin
               wcnt_d = '0;
               fare_d = fare_add(fare_q, FareW1'(1));
            end else begin
               wcnt_d = wcnt_q + WaitW'(1);
            end
         end
      end
   end

   // Start a conversion on a fare change, or remember it while the converter is busy.
   always_comb begin
      fare_chg   = (fare_d != fare_q);
      conv_start = (fare_chg || pending_q) && !conv_busy;
      pending_d  = pending_q;
      if (conv_start) begin
         pending_d = 1'b0;
      end else if (fare_chg) begin
         pending_d = 1'b1;
      end
   end

   // Segment decode with leading-zero blanking; digit 0 is always shown.
   always_comb begin
      seg_d = seg_q;
      seen  = 1'b0;
      nib   = 4'd0;
      if (conv_done) begin
         for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = conv_bcd[4*i +: 4];
            if (nib != 4'd0) seen = 1'b1;
            if (seen || i == 0) begin
               seg_d[7*i +: 7] = seg_code(nib);
            end else begin
               seg_d[7*i +: 7] = SegBlank;
            end
         end
      end
   end

   bin2bcd_seq #(
      .FARE_W (FARE_W),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (fare_d),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

endmodule

// File: doc/taxi_meter_gen.md
Name: taxi_meter_gen

Overview:
Parametrised next-generation fare meter that merges fare calculation and seven-segment display into one clocked block. Adds a trip FSM (idle/run/pause/hold), a night-rate mode and waiting-time charging. Fare is converted to BCD by a sequential double-dabble converter and driven to DIGITS active-low seven-segment digits with leading-zero blanking. It sits at the top of the meter datapath and takes pulse inputs from the wheel sensor and a 1 Hz tick.

Parameters:
DIGITS, 4, number of displayed fare digits; fare saturates at FARE_MAX = 10^DIGITS-1.
FARE_W, 16, binary fare width; must satisfy FARE_MAX < 2^FARE_W.
PRICE_W, 4, width of the init_cost and per_cost prices.
DIST_W, 16, width of the distance counter and add_mile.
WAIT_TICKS, 60, wait_tick pulses per 1-unit waiting charge.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-low reset
set  in  1  load config; honoured only in IDLE or HOLD
init_cost  in  PRICE_W  starting fare
per_cost  in  PRICE_W  fare per distance unit beyond add_mile
add_mile  in  DIST_W  distance included in starting fare
night  in  1  night rate (per_cost x2); sampled at start
start  in  1  begin trip (IDLE/HOLD -> RUN)
pause  in  1  level; 1 = waiting (RUN <-> PAUSE)
stop  in  1  end trip (RUN/PAUSE -> HOLD)
dist_pulse  in  1  one-cycle pulse per distance unit
wait_tick  in  1  one-cycle 1 Hz enable
fare  out  FARE_W  current binary fare
distance  out  DIST_W  trip distance
state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 HOLD
seg  out  7*DIGITS  active-low segments, digit i at [7i+6:7i], order gfedcba

Behaviour:
- Reset (rst=0 at edge): state=IDLE; fare=0; distance=0; wait count=0; config regs=0; night latch=0; converter idle; BCD=0. seg: digit0=7'b1000000 ("0"), others 7'b1111111 (blank).
- set in IDLE/HOLD: register init_cost, per_cost and add_mile next edge. Ignored in RUN/PAUSE.
- IDLE: start -> RUN. Same edge: fare=init_cost, distance=0, wait count=0, night latched. stop/pause ignored.
- RUN: dist_pulse -> distance+1 (saturates at all-ones). If the new distance > add_mile, fare += per_cost<<night. pause=1 -> PAUSE.
- PAUSE: dist_pulse still counts distance but adds no fare. Each wait_tick increments wait count. When the count reaches WAIT_TICKS: fare += 1 and count clears. pause=0 -> RUN; wait count is kept.
- stop in RUN/PAUSE -> HOLD. A same-cycle dist_pulse or wait_tick is applied first. Priority: stop > pause transition.
- HOLD: fare and distance frozen and displayed. start -> RUN with a fresh trip (same as from IDLE).
- Fare arithmetic: widen to FARE_W+1 bits; result clamps to FARE_MAX. Once at FARE_MAX it stays there.
- Display: on any edge where fare changes, the converter latches fare and runs FARE_W shift/add-3 cycles. BCD and seg register on the next cycle, so latency is FARE_W+2 cycles from fare update to seg.
- A fare change during conversion sets a pending flag. A restart with the latest fare follows immediately after completion; intermediate values may be skipped.
- Blanking: digit i>0 blank if it and all higher digits are 0. Digit 0 is never blanked.
- rst mid-operation overrides everything, including an in-flight conversion.

Decomposition:
- Shared package: state encoding, active-low seven-segment code table for 0-9 and blank, FARE_MAX function of DIGITS.
- Sub-module bin2bcd_seq (params FARE_W, DIGITS). Ports: clk, rst, start, bin, busy, done, bcd. Implements the sequential double-dabble.
- Top keeps the FSM, counters, pending flag and segment decode/blanking.

Test Plan:
- set init=5, per=2, add_mile=3; start; 5 dist_pulses -> distance=5, fare=9. After FARE_W+2 cycles: seg digit0=7'b0010000, digits1-3 blank.
- Same config with night=1 at start; 5 pulses -> fare=13. Digit1 shows 1 (7'b1111001), digit0 shows 3 (7'b0110000).
- WAIT_TICKS=4; RUN, pause=1; 9 wait_ticks plus 2 dist_pulses -> fare=init+2, distance=2. pause=0, then 3 more ticks -> no charge.
- stop asserted with dist_pulse (distance 4 > add_mile 3) -> fare includes that pulse, state=HOLD. Later pulses change nothing. set accepted in HOLD; start -> fare=new init.
- per=15, add_mile=0, init=15; 700 pulses -> fare=9999 and stays. Display shows 9999. Back-to-back pulses during conversion -> final seg matches final fare.
- rst=0 mid-RUN during a conversion -> next cycle state=IDLE, fare=0, seg digit0 "0", others blank. start with no set -> fare=0.
